acc_stream_buffer: RTL

// - Sits between the Lua/HSE-driven value producer (valid/value pulses, no ready) and the accumulate stage.
// - Buffers bursts in a DEPTH-entry FIFO and drains one entry per cycle into a running accumulator when drain_en is high.
// - Counts entries dropped on overflow and entries accumulated; exposes fill level for Lua-side pacing.

---
 rtl/acc_stream_buffer.sv | 94 +++++++++
 1 files changed

// File: rtl/acc_stream_buffer.sv
// Stream buffer: DEPTH-entry FIFO that drains one entry per cycle into a running accumulator.
// Define ACC_STREAM_BUFFER_SATURATE_EN to clamp the accumulator instead of wrapping it.
module acc_stream_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_value,
  input  logic                       drain_en,
  input  logic                       clear,
  output logic [DATA_W-1:0]          accumulator,
  output logic [CNT_W-1:0]           acc_count,
  output logic [CNT_W-1:0]           drop_count,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic                       acc_wrapped
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [LW-1:0]     r_level;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_acc_cnt, r_drop_cnt;
  logic              r_wrapped, r_full, r_empty;

  logic              w_pop, w_push, w_drop, w_wr_en;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_acc_nxt;
  logic [LW-1:0]     w_level_nxt;

  // pop only sees entries present before the edge, so an empty FIFO never bypasses
  assign w_pop   = drain_en & ~r_empty;
  assign w_push  = in_valid & (~r_full | w_pop);
  assign w_drop  = in_valid & r_full & ~w_pop;
  assign w_wr_en = w_push & reset_n & ~clear;
  assign w_sum   = {1'b0, r_acc} + {1'b0, r_mem[r_rptr]};

`ifdef ACC_STREAM_BUFFER_SATURATE_EN
  assign w_acc_nxt = w_sum[DATA_W] ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
`else
  assign w_acc_nxt = w_sum[DATA_W-1:0];
`endif

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)      w_level_nxt = r_level + LW'(1);
    else if (w_pop && !w_push) w_level_nxt = r_level - LW'(1);
  end

  // storage needs no reset; occupancy is tracked by pointers and level
  always_ff @(posedge clock) begin
    if (w_wr_en) r_mem[r_wptr] <= in_value;
  end

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_acc      <= '0;
      r_acc_cnt  <= '0;
      r_drop_cnt <= '0;
      r_wrapped  <= 1'b0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
        r_acc  <= w_acc_nxt;
        if (w_sum[DATA_W])         r_wrapped <= 1'b1;
        if (r_acc_cnt != '1)       r_acc_cnt <= r_acc_cnt + CNT_W'(1);
      end
      if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LW'(DEPTH));
      r_empty <= (w_level_nxt == '0);
    end
  end

  assign accumulator = r_acc;
  assign acc_count   = r_acc_cnt;
  assign drop_count  = r_drop_cnt;
  assign level       = r_level;
  assign full        = r_full;
  assign empty       = r_empty;
  assign acc_wrapped = r_wrapped;
endmodule
